// File: rtl/alu_rs.sv
// Reservation station in front of the combinational ALU: buffers issued ops, snoops the
// ALU/LSB common data buses for pending operands, and dispatches one ready op per cycle.
module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4,
    parameter int OPT_W   = 5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,

    input  logic               issue_valid_in,
    input  logic [OPT_W-1:0]   issue_opt_in,
    input  logic [31:0]        issue_vj_in,
    input  logic [31:0]        issue_vk_in,
    input  logic               issue_qj_busy_in,
    input  logic               issue_qk_busy_in,
    input  logic [ROB_W-1:0]   issue_qj_in,
    input  logic [ROB_W-1:0]   issue_qk_in,
    input  logic [31:0]        issue_imm_in,
    input  logic [31:0]        issue_pc_in,
    input  logic [ROB_W-1:0]   issue_rob_in,

    input  logic               cdb_alu_valid_in,
    input  logic [ROB_W-1:0]   cdb_alu_rob_in,
    input  logic [31:0]        cdb_alu_val_in,
    input  logic               cdb_lsb_valid_in,
    input  logic [ROB_W-1:0]   cdb_lsb_rob_in,
    input  logic [31:0]        cdb_lsb_val_in,

    output logic               full_out,
    output logic               alu_valid_out,
    output logic [OPT_W-1:0]   alu_opt_out,
    output logic [31:0]        alu_rs1_out,
    output logic [31:0]        alu_rs2_out,
    output logic [31:0]        alu_imm_out,
    output logic [31:0]        alu_pc_out,
    output logic [ROB_W-1:0]   alu_rob_out
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qj_busy;
    logic [RS_SIZE-1:0] qk_busy;
    logic [CNT_W-1:0]   count;

    logic [OPT_W-1:0]   opt [RS_SIZE];
    logic [31:0]        vj  [RS_SIZE];
    logic [31:0]        vk  [RS_SIZE];
    logic [ROB_W-1:0]   qj  [RS_SIZE];
    logic [ROB_W-1:0]   qk  [RS_SIZE];
    logic [31:0]        imm [RS_SIZE];
    logic [31:0]        pc  [RS_SIZE];
    logic [ROB_W-1:0]   rob [RS_SIZE];

    logic [RS_SIZE-1:0] ready;
    logic [RS_SIZE-1:0] wj_alu, wj_lsb, wk_alu, wk_lsb;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic               do_issue;
    logic [CNT_W-1:0]   count_next;

    logic               iss_j_alu, iss_j_lsb, iss_k_alu, iss_k_lsb;
    logic               iss_qj_busy, iss_qk_busy;
    logic [31:0]        iss_vj, iss_vk;

    assign full_out  = (count == CNT_W'(RS_SIZE));
    assign do_issue  = issue_valid_in && !full_out;
    assign ready     = busy & ~qj_busy & ~qk_busy;
    assign sel_found = |ready;

    // Lowest-index free slot and lowest-index ready slot, both from registered state.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        free_idx = '0;
        sel_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
            if (ready[i]) sel_idx  = IDX_W'(i);
        end
    end

    always_comb begin
        wj_alu = '0;
        wj_lsb = '0;
        wk_alu = '0;
        wk_lsb = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            wj_alu[i] = busy[i] && qj_busy[i] && cdb_alu_valid_in && (qj[i] == cdb_alu_rob_in);
            wj_lsb[i] = busy[i] && qj_busy[i] && cdb_lsb_valid_in && (qj[i] == cdb_lsb_rob_in);
            wk_alu[i] = busy[i] && qk_busy[i] && cdb_alu_valid_in && (qk[i] == cdb_alu_rob_in);
            wk_lsb[i] = busy[i] && qk_busy[i] && cdb_lsb_valid_in && (qk[i] == cdb_lsb_rob_in);
        end
    end

    // Issue-cycle bypass: a tag broadcast in the same cycle is captured directly.
    assign iss_j_alu   = issue_qj_busy_in && cdb_alu_valid_in && (issue_qj_in == cdb_alu_rob_in);
    assign iss_j_lsb   = issue_qj_busy_in && cdb_lsb_valid_in && (issue_qj_in == cdb_lsb_rob_in);
    assign iss_k_alu   = issue_qk_busy_in && cdb_alu_valid_in && (issue_qk_in == cdb_alu_rob_in);
    assign iss_k_lsb   = issue_qk_busy_in && cdb_lsb_valid_in && (issue_qk_in == cdb_lsb_rob_in);
    assign iss_qj_busy = issue_qj_busy_in && !iss_j_alu && !iss_j_lsb;
    assign iss_qk_busy = issue_qk_busy_in && !iss_k_alu && !iss_k_lsb;
    assign iss_vj      = iss_j_alu ? cdb_alu_val_in : (iss_j_lsb ? cdb_lsb_val_in : issue_vj_in);
    assign iss_vk      = iss_k_alu ? cdb_alu_val_in : (iss_k_lsb ? cdb_lsb_val_in : issue_vk_in);

    always_comb begin
        count_next = count;
        case ({do_issue, sel_found})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_in) begin
            busy          <= '0;
            qj_busy       <= '0;
            qk_busy       <= '0;
            count         <= '0;
            alu_valid_out <= 1'b0;
            alu_opt_out   <= '0;
            alu_rs1_out   <= '0;
            alu_rs2_out   <= '0;
            alu_imm_out   <= '0;
            alu_pc_out    <= '0;
            alu_rob_out   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy          <= '0;
                qj_busy       <= '0;
                qk_busy       <= '0;
                count         <= '0;
                alu_valid_out <= 1'b0;
            end else begin
                qj_busy       <= qj_busy & ~(wj_alu | wj_lsb);
                qk_busy       <= qk_busy & ~(wk_alu | wk_lsb);
                alu_valid_out <= sel_found;
                if (sel_found) begin
                    busy[sel_idx] <= 1'b0;
                    alu_opt_out   <= opt[sel_idx];
                    alu_rs1_out   <= vj[sel_idx];
                    alu_rs2_out   <= vk[sel_idx];
                    alu_imm_out   <= imm[sel_idx];
                    alu_pc_out    <= pc[sel_idx];
                    alu_rob_out   <= rob[sel_idx];
                end
                // The free slot is never the selected slot, so these writes cannot collide.
                if (do_issue) begin
                    busy[free_idx]    <= 1'b1;
                    qj_busy[free_idx] <= iss_qj_busy;
                    qk_busy[free_idx] <= iss_qk_busy;
                end
                count <= count_next;
            end
        end
    end

    // NOTE: payload storage is not reset; it is only ever read behind a busy bit that is.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (wj_alu[i])      vj[i] <= cdb_alu_val_in;
                else if (wj_lsb[i]) vj[i] <= cdb_lsb_val_in;
                if (wk_alu[i])      vk[i] <= cdb_alu_val_in;
                else if (wk_lsb[i]) vk[i] <= cdb_lsb_val_in;
            end
            if (do_issue) begin
                opt[free_idx] <= issue_opt_in;
                vj[free_idx]  <= iss_vj;
                vk[free_idx]  <= iss_vk;
                qj[free_idx]  <= issue_qj_in;
                qk[free_idx]  <= issue_qk_in;
                imm[free_idx] <= issue_imm_in;
                pc[free_idx]  <= issue_pc_in;
                rob[free_idx] <= issue_rob_in;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed-vector bench for alu_rs: issue, bypass, wakeup, ordering, full, flush, stall, reset.
module tb_alu_rs;

    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;

    logic        clk_in, rst_in, rdy_in, flush_in;
    logic        issue_valid_in;
    logic [4:0]  issue_opt_in;
    logic [31:0] issue_vj_in, issue_vk_in, issue_imm_in, issue_pc_in;
    logic        issue_qj_busy_in, issue_qk_busy_in;
    logic [3:0]  issue_qj_in, issue_qk_in, issue_rob_in;
    logic        cdb_alu_valid_in, cdb_lsb_valid_in;
    logic [3:0]  cdb_alu_rob_in, cdb_lsb_rob_in;
    logic [31:0] cdb_alu_val_in, cdb_lsb_val_in;
    logic        full_out, alu_valid_out;
    logic [4:0]  alu_opt_out;
    logic [31:0] alu_rs1_out, alu_rs2_out, alu_imm_out, alu_pc_out;
    logic [3:0]  alu_rob_out;

    alu_rs #(.RS_SIZE(8), .ROB_W(4), .OPT_W(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .issue_valid_in(issue_valid_in), .issue_opt_in(issue_opt_in),
        .issue_vj_in(issue_vj_in), .issue_vk_in(issue_vk_in),
        .issue_qj_busy_in(issue_qj_busy_in), .issue_qk_busy_in(issue_qk_busy_in),
        .issue_qj_in(issue_qj_in), .issue_qk_in(issue_qk_in),
        .issue_imm_in(issue_imm_in), .issue_pc_in(issue_pc_in), .issue_rob_in(issue_rob_in),
        .cdb_alu_valid_in(cdb_alu_valid_in), .cdb_alu_rob_in(cdb_alu_rob_in),
        .cdb_alu_val_in(cdb_alu_val_in),
        .cdb_lsb_valid_in(cdb_lsb_valid_in), .cdb_lsb_rob_in(cdb_lsb_rob_in),
        .cdb_lsb_val_in(cdb_lsb_val_in),
        .full_out(full_out), .alu_valid_out(alu_valid_out), .alu_opt_out(alu_opt_out),
        .alu_rs1_out(alu_rs1_out), .alu_rs2_out(alu_rs2_out), .alu_imm_out(alu_imm_out),
        .alu_pc_out(alu_pc_out), .alu_rob_out(alu_rob_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic quiet();
        issue_valid_in   = 1'b0;
        cdb_alu_valid_in = 1'b0;
        cdb_lsb_valid_in = 1'b0;
        flush_in         = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic jb, input logic [3:0] qj, input logic kb,
                         input logic [3:0] qk, input logic [3:0] rob);
        issue_valid_in   = 1'b1;
        issue_opt_in     = op;
        issue_vj_in      = vj;
        issue_vk_in      = vk;
        issue_qj_busy_in = jb;
        issue_qj_in      = qj;
        issue_qk_busy_in = kb;
        issue_qk_in      = qk;
        issue_rob_in     = rob;
        issue_imm_in     = 32'h100 + 32'(rob);
        issue_pc_in      = 32'h1000 + 32'(rob) * 4;
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        quiet();
        issue(OP_ADD, 0, 0, 0, 0, 0, 0, 0);
        issue_valid_in = 1'b0;
        cdb_alu_rob_in = 0; cdb_alu_val_in = 0;
        cdb_lsb_rob_in = 0; cdb_lsb_val_in = 0;

        #12;
        check("reset_full", 32'(full_out), 0);
        check("reset_valid", 32'(alu_valid_out), 0);
        check("reset_rs1", alu_rs1_out, 0);
        check("reset_rob", 32'(alu_rob_out), 0);
        check("reset_opt", 32'(alu_opt_out), 0);

        // Basic ADD, accepted on the first edge after reset release.
        rst_in = 1'b1;
        issue(OP_ADD, 5, 7, 0, 0, 0, 0, 3);
        step();
        quiet();
        check("add_not_yet", 32'(alu_valid_out), 0);
        step();
        check("add_valid", 32'(alu_valid_out), 1);
        check("add_opt", 32'(alu_opt_out), 32'(OP_ADD));
        check("add_rs1", alu_rs1_out, 5);
        check("add_rs2", alu_rs2_out, 7);
        check("add_rob", 32'(alu_rob_out), 3);
        check("add_imm", alu_imm_out, 32'h103);
        check("add_pc", alu_pc_out, 32'h100c);
        step();
        check("add_drop", 32'(alu_valid_out), 0);

        // SUB waiting on tag 2, woken by the LSB bus three cycles later.
        issue(OP_SUB, 0, 1, 1, 2, 0, 0, 6);
        step();
        quiet();
        step();
        step();
        check("sub_wait", 32'(alu_valid_out), 0);
        cdb_lsb_valid_in = 1'b1; cdb_lsb_rob_in = 2; cdb_lsb_val_in = 10;
        step();
        quiet();
        check("sub_capture_edge", 32'(alu_valid_out), 0);
        step();
        check("sub_valid", 32'(alu_valid_out), 1);
        check("sub_opt", 32'(alu_opt_out), 32'(OP_SUB));
        check("sub_rs1", alu_rs1_out, 10);
        check("sub_rs2", alu_rs2_out, 1);
        check("sub_rob", 32'(alu_rob_out), 6);

        // Issue-cycle bypass from the ALU bus.
        issue(OP_ADD, 0, 3, 1, 4, 0, 0, 8);
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_in = 4; cdb_alu_val_in = 32'h55;
        step();
        quiet();
        check("byp_not_yet", 32'(alu_valid_out), 0);
        step();
        check("byp_valid", 32'(alu_valid_out), 1);
        check("byp_rs1", alu_rs1_out, 32'h55);
        check("byp_rs2", alu_rs2_out, 3);
        check("byp_rob", 32'(alu_rob_out), 8);
        step();

        // Fill all eight entries, each pending on tag i+8, rob i.
        for (int i = 0; i < 8; i++) begin
            issue(OP_ADD, 0, 32'(i), 1, 4'(i + 8), 0, 0, 4'(i));
            step();
            if (i == 6) check("fill_seven_not_full", 32'(full_out), 0);
        end
        quiet();
        check("fill_full", 32'(full_out), 1);
        issue(OP_ADD, 1, 1, 0, 0, 0, 0, 9);
        step();
        quiet();
        check("ninth_full", 32'(full_out), 1);
        check("ninth_no_dispatch", 32'(alu_valid_out), 0);
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_in = 13; cdb_alu_val_in = 32'h500;
        cdb_lsb_valid_in = 1'b1; cdb_lsb_rob_in = 10; cdb_lsb_val_in = 32'h200;
        step();
        quiet();
        check("wake_edge_valid", 32'(alu_valid_out), 0);
        check("wake_edge_full", 32'(full_out), 1);
        step();
        check("first_valid", 32'(alu_valid_out), 1);
        check("first_rob", 32'(alu_rob_out), 2);
        check("first_rs1", alu_rs1_out, 32'h200);
        check("first_rs2", alu_rs2_out, 2);
        check("first_full_drop", 32'(full_out), 0);
        step();
        check("second_valid", 32'(alu_valid_out), 1);
        check("second_rob", 32'(alu_rob_out), 5);
        check("second_rs1", alu_rs1_out, 32'h500);
        step();
        check("ninth_never", 32'(alu_valid_out), 0);

        // Flush the leftovers, fill three, then flush alongside an issue.
        flush_in = 1'b1;
        step();
        quiet();
        check("flush1_full", 32'(full_out), 0);
        for (int i = 0; i < 3; i++) begin
            issue(OP_ADD, 0, 0, 1, 1, 0, 0, 4'(i));
            step();
        end
        issue(OP_ADD, 2, 2, 0, 0, 0, 0, 7);
        flush_in = 1'b1;
        step();
        quiet();
        check("flush2_full", 32'(full_out), 0);
        check("flush2_valid", 32'(alu_valid_out), 0);
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_in = 1; cdb_alu_val_in = 32'h77;
        step();
        quiet();
        check("flush2_issue_dropped", 32'(alu_valid_out), 0);
        step();
        check("flush2_entries_gone", 32'(alu_valid_out), 0);
        // Count must be back at zero: exactly eight more issues are needed to fill.
        for (int i = 0; i < 8; i++) begin
            issue(OP_ADD, 0, 0, 1, 3, 0, 0, 4'(i));
            step();
            if (i == 6) check("count_seven", 32'(full_out), 0);
        end
        quiet();
        check("count_eight", 32'(full_out), 1);
        flush_in = 1'b1;
        step();
        quiet();

        // Stall: a ready entry and a live CDB while rdy is low.
        issue(OP_SUB, 0, 2, 1, 6, 0, 0, 4);
        step();
        issue(OP_ADD, 11, 22, 0, 0, 0, 0, 12);
        step();
        quiet();
        rdy_in = 1'b0;
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_in = 6; cdb_alu_val_in = 32'h66;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", 32'(alu_valid_out), 0);
            check("stall_rob", 32'(alu_rob_out), 5);
            check("stall_rs1", alu_rs1_out, 32'h500);
        end
        rdy_in = 1'b1;
        quiet();
        step();
        check("resume_valid", 32'(alu_valid_out), 1);
        check("resume_rs1", alu_rs1_out, 11);
        check("resume_rs2", alu_rs2_out, 22);
        check("resume_rob", 32'(alu_rob_out), 12);
        step();
        check("lost_wakeup", 32'(alu_valid_out), 0);
        cdb_alu_valid_in = 1'b1; cdb_alu_rob_in = 6; cdb_alu_val_in = 32'h66;
        step();
        quiet();
        check("retry_edge", 32'(alu_valid_out), 0);
        step();
        check("retry_valid", 32'(alu_valid_out), 1);
        check("retry_rs1", alu_rs1_out, 32'h66);
        check("retry_rs2", alu_rs2_out, 2);
        check("retry_rob", 32'(alu_rob_out), 4);
        check("retry_opt", 32'(alu_opt_out), 32'(OP_SUB));

        // Asynchronous reset mid-cycle, then issue on the first edge after release.
        issue(OP_ADD, 3, 4, 0, 0, 0, 0, 9);
        step();
        quiet();
        step();
        check("pre_rst_valid", 32'(alu_valid_out), 1);
        check("pre_rst_rob", 32'(alu_rob_out), 9);
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_valid", 32'(alu_valid_out), 0);
        check("async_rst_rob", 32'(alu_rob_out), 0);
        check("async_rst_rs1", alu_rs1_out, 0);
        check("async_rst_full", 32'(full_out), 0);
        #1;
        rst_in = 1'b1;
        issue(OP_ADD, 8, 9, 0, 0, 0, 0, 10);
        step();
        quiet();
        step();
        check("post_rst_valid", 32'(alu_valid_out), 1);
        check("post_rst_rs1", alu_rs1_out, 8);
        check("post_rst_rob", 32'(alu_rob_out), 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
